instr_fetch_unit: RTL and testbench

//   IF-stage producer that drives the IF/ID pipeline register: owns the PC,

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_queue.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e : request-tracking FSM states (RUN, WAIT, KILL)
//   fetch_entry_t : one buffered fetch, {pc_plus4, instr}
//   NOP_INSTR     : word presented when nothing is buffered
//   PC_STEP       : PC increment between sequential fetches
//   pc_inc()      : modulo-2^32 PC advance (low two bits pass through)
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // live request outstanding
    KILL = 2'd2   // request outstanding whose data must be thrown away
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'd0;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;

  // Plain 32-bit add: 32'hFFFF_FFFC wraps to 0, low bits are untouched.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch buffer between the imem response and the IF/ID register.
// Entry 0 is always the head, so the head is a plain register read.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears occupancy only)
//   push     in   enqueue wr_entry this cycle
//   pop      in   consume the head this cycle (ignored when empty)
//   clear    in   drop all entries; overrides push and pop
//   wr_entry in   entry to enqueue
//   head     out  current head, all zeros when empty
//   count    out  number of valid entries (0..2)
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t ent0;
  fetch_entry_t ent1;
  logic [1:0]   count_q;
  logic         pop_eff;

  assign pop_eff = pop && (count_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
    end else if (clear) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_q + {1'b0, push} - {1'b0, pop_eff};
    end
  end

  // Storage carries no reset: it is only observed through count_q.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (pop_eff) begin
        // Shift down; a simultaneous push lands right behind the new head.
        if (push && (count_q == 2'd1)) begin
          ent0 <= wr_entry;
        end else begin
          ent0 <= ent1;
        end
        if (push && (count_q == 2'd2)) begin
          ent1 <= wr_entry;
        end
      end else if (push) begin
        if (count_q == 2'd0) begin
          ent0 <= wr_entry;
        end else begin
          ent1 <= wr_entry;
        end
      end
    end
  end

  assign head  = (count_q != 2'd0) ? ent0 : '{pc_plus4: 32'd0, instr: NOP_INSTR};
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF-stage producer feeding the IF/ID pipeline register. Owns the PC, fetches
// from instruction memory over a req/ack handshake and buffers responses in a
// two-entry queue. The queue head is presented as {PC_o, instruction_o};
// an empty queue presents a zero bubble.
//   clk_i           in   clock, rising edge
//   rst_i           in   asynchronous active-low reset
//   stall_i         in   IF/ID holds; head not consumed
//   branch_i        in   redirect; IF/ID flushes the same cycle
//   branch_target_i in   redirect address
//   imem_req_o      out  fetch request, held until imem_ack_i
//   imem_addr_o     out  fetch address, stable while imem_req_o=1
//   imem_ack_i      in   response valid (may coincide with the request cycle)
//   imem_rdata_i    in   instruction word, valid with imem_ack_i
//   PC_o            out  head fetch address + 4, 0 when empty
//   instruction_o   out  head word, NOP (0) when empty
// Optional (macro IF_PERF_CNT_EN):
//   bubble_cnt_o    out  cycles with an empty queue and no stall
//   redirect_cnt_o  out  cycles with branch_i asserted
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] PC_o,
  output logic [31:0] instruction_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt_o,
  output logic [31:0] redirect_cnt_o
`endif
);

  localparam logic [2:0] QLIM = 3'(QDEPTH);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  req_addr_q;
  logic [31:0]  req_addr_d;

  logic         push;
  logic         pop;
  logic         space;
  logic [1:0]   q_count;
  logic [2:0]   cnt_next;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  // Only a live (non-killed) response that is not being flushed is kept.
  assign push = (state_q == WAIT) && imem_ack_i && !branch_i;
  assign pop  = !stall_i && (q_count != 2'd0);

  // Occupancy after this edge; a new request is only launched when its
  // response is guaranteed a free slot, so the queue can never overflow.
  assign cnt_next = {1'b0, q_count} - {2'b00, pop} + {2'b00, push};
  assign space    = cnt_next < QLIM;

  assign wr_entry = '{pc_plus4: pc_inc(req_addr_q), instr: imem_rdata_i};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      RUN: begin
        if (branch_i) begin
          pc_d = branch_target_i;
        end else if (space) begin
          state_d    = WAIT;
          req_addr_d = pc_q;
          pc_d       = pc_inc(pc_q);
        end
      end
      WAIT: begin
        if (branch_i) begin
          pc_d = branch_target_i;
          // An unanswered request cannot be withdrawn; wait it out in KILL.
          state_d = imem_ack_i ? RUN : KILL;
        end else if (imem_ack_i) begin
          if (space) begin
            req_addr_d = pc_q;
            pc_d       = pc_inc(pc_q);
          end else begin
            state_d = RUN;
          end
        end
      end
      KILL: begin
        if (branch_i) begin
          pc_d = branch_target_i;
        end
        // Leave on the stale ack even if a new redirect arrives with it,
        // otherwise we would wait for an ack that never comes.
        if (imem_ack_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign imem_req_o  = (state_q != RUN);
  assign imem_addr_o = req_addr_q;

  fetch_queue u_queue (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .push     (push),
    .pop      (pop),
    .clear    (branch_i),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (q_count)
  );

  assign PC_o          = head.pc_plus4;
  assign instruction_o = head.instr;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o   <= 32'd0;
      redirect_cnt_o <= 32'd0;
    end else begin
      if ((q_count == 2'd0) && !stall_i) begin
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
      if (branch_i) begin
        redirect_cnt_o <= redirect_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a configurable-latency imem
// responder and a scoreboard of expected IF/ID heads.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] redirect_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (target),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_ack_i      (ack),
    .imem_rdata_i    (rdata),
    .PC_o            (pc_o),
    .instruction_o   (instr_o)
`ifdef IF_PERF_CNT_EN
    ,
    .bubble_cnt_o    (bubble_cnt),
    .redirect_cnt_o  (redirect_cnt)
`endif
  );

  // Instruction memory model: ack after ack_delay waiting cycles.
  logic ack_en;
  logic ack_force;
  int   ack_delay;
  int   wait_cnt;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign ack   = ack_force || (req && ack_en && (wait_cnt >= ack_delay));
  assign rdata = word_of(addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wait_cnt <= 0;
    else if (req && !ack) wait_cnt <= wait_cnt + 1;
    else                 wait_cnt <= 0;
  end

  // Scoreboard and reference model state.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_addr;
  logic        stale;
  logic        prev_pending;
  logic [31:0] prev_addr;
  int          bub_m;
  int          red_m;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_addr     = 32'h0000_0000;
    stale        = 1'b0;
    prev_pending = 1'b0;
    prev_addr    = 32'd0;
    bub_m        = 0;
    red_m        = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic        s_req, s_ack, s_br, s_st, fetched;
    logic [31:0] s_addr, s_tgt, nxt;
    exp_t        e;
    #1;
    if (sb.size() > 0) begin
      chk("pc_head", pc_o, sb[0].pc);
      chk("instr_head", instr_o, sb[0].ins);
    end else begin
      chk("pc_bubble", pc_o, 32'd0);
      chk("instr_bubble", instr_o, 32'd0);
    end
    if (prev_pending) begin
      chk("req_held", {31'd0, req}, 32'd1);
      chk("addr_stable", addr, prev_addr);
    end
    s_req = req; s_ack = ack; s_br = branch; s_st = stall;
    s_addr = addr; s_tgt = target;
    if (s_req && s_ack && !stale) chk("fetch_addr", s_addr, exp_addr);
    if ((sb.size() == 0) && !s_st) bub_m++;
    if (s_br) red_m++;
    @(posedge clk);
    prev_pending = s_req && !s_ack;
    prev_addr    = s_addr;
    fetched      = s_req && s_ack && !stale;
    if (s_req && s_ack) stale = 1'b0;
    if (s_br) begin
      sb.delete();
      if (s_req && !s_ack) stale = 1'b1;
      exp_addr = s_tgt;
    end else begin
      if (!s_st && (sb.size() > 0)) e = sb.pop_front();
      if (fetched) begin
        nxt   = exp_addr + 32'd4;
        e.pc  = nxt;
        e.ins = word_of(exp_addr);
        sb.push_back(e);
        exp_addr = nxt;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'd0;
    ack_en = 1'b1; ack_force = 1'b0; ack_delay = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: streaming with same-cycle acks
    chk("t1_idle_req", {31'd0, req}, 32'd0);
    repeat (2) cycle();
    #1;
    chk("t1_first_pc", pc_o, 32'd4);
    chk("t1_first_instr", instr_o, word_of(32'd0));
    cycle();
    #1;
    chk("t1_second_pc", pc_o, 32'd8);
    repeat (6) cycle();

    // 2: stall while streaming fills the queue and stops requests
    stall = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_req_dropped", {31'd0, req}, 32'd0);
      cycle();
    end
    stall = 1'b0;
    repeat (6) cycle();

    // 3: slow memory
    ack_delay = 3;
    repeat (14) cycle();

    // 4: redirect while a request is outstanding
    ack_delay = 2;
    for (int i = 0; i < 20 && !(req && !ack && wait_cnt == 0); i++) cycle();
    chk("t4_in_wait", {31'd0, req && !ack}, 32'd1);
    target = 32'h0000_0100; branch = 1'b1;
    cycle();
    branch = 1'b0;
    #1;
    chk("t4_queue_empty", instr_o, 32'd0);
    for (int i = 0; i < 20 && !(req && !stale); i++) cycle();
    chk("t4_redirect_addr", addr, 32'h0000_0100);
    repeat (8) cycle();

    // 5: redirect with full queue under stall, then redirect on an ack
    ack_delay = 0;
    repeat (4) cycle();
    stall = 1'b1;
    repeat (3) cycle();
    target = 32'h0000_0202; branch = 1'b1;
    cycle();
    branch = 1'b0;
    #1;
    chk("t5_cleared", pc_o, 32'd0);
    stall = 1'b0;
    repeat (6) cycle();
    #1;
    chk("t5_ack_coincide", {31'd0, req && ack}, 32'd1);
    target = 32'h0000_0300; branch = 1'b1;
    cycle();
    branch = 1'b0;
    #1;
    chk("t5_run_after_drop", {31'd0, req}, 32'd0);
    repeat (5) cycle();
    // redirect again while already killing
    ack_delay = 4;
    for (int i = 0; i < 20 && !(req && !ack && wait_cnt == 0); i++) cycle();
    target = 32'h0000_0400; branch = 1'b1;
    cycle();
    #1;
    chk("t5_kill_req", {31'd0, req}, 32'd1);
    target = 32'h0000_0480;
    cycle();
    branch = 1'b0;
    repeat (12) cycle();

    // 6: PC wrap-around
    ack_delay = 0;
    repeat (6) cycle();
    #1;
    chk("t6_streaming", {31'd0, req && ack}, 32'd1);
    target = 32'hFFFF_FFFC; branch = 1'b1;
    cycle();
    branch = 1'b0;
    cycle();
    #1;
    chk("t6_wrap_from", addr, 32'hFFFF_FFFC);
    cycle();
    #1;
    chk("t6_wrap_to", addr, 32'h0000_0000);
    chk("t6_wrap_pc", pc_o, 32'h0000_0000);
    chk("t6_wrap_instr", instr_o, word_of(32'hFFFF_FFFC));
    repeat (3) cycle();

    // 6: async reset in the middle of an outstanding request
    ack_en = 1'b0;
    repeat (3) cycle();
    chk("t6_pending", {31'd0, req}, 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("perf_bubbles", bubble_cnt, 32'(bub_m));
    chk("perf_redirects", redirect_cnt, 32'(red_m));
`endif
    #2;
    rst_n = 1'b0;
    ack_force = 1'b1;
    #1;
    chk("t6_req_async", {31'd0, req}, 32'd0);
    chk("t6_addr_async", addr, 32'd0);
    chk("t6_pc_async", pc_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    ack_en = 1'b1;
    rst_n = 1'b1;
`ifdef IF_PERF_CNT_EN
    chk("perf_bubbles_rst", bubble_cnt, 32'd0);
    chk("perf_redirects_rst", redirect_cnt, 32'd0);
`endif
    cycle();
    ack_force = 1'b0;
    cycle();
    #1;
    chk("t6_after_rst_pc", pc_o, 32'd4);
    chk("t6_after_rst_instr", instr_o, word_of(32'd0));
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
